// File: rtl/chip8_audio_pkg.sv
// Shared types and codes for the CHIP-8 audio path: envelope states,
// config register addresses, timbre codes and a volume-step helper.
package chip8_audio_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } env_state_t;

    localparam logic [1:0] CFG_TIMBRE = 2'd0;
    localparam logic [1:0] CFG_TONE   = 2'd1;
    localparam logic [1:0] CFG_VOL    = 2'd2;

    localparam logic [1:0] TIMBRE_SINE     = 2'd0;
    localparam logic [1:0] TIMBRE_SQUARE   = 2'd1;
    localparam logic [1:0] TIMBRE_TRIANGLE = 2'd2;
    localparam logic [1:0] TIMBRE_SAW      = 2'd3;

    // One LSB toward tgt; never overshoots, so the result stays inside 0..7.
    function automatic logic [2:0] vol_toward(input logic [2:0] cur, input logic [2:0] tgt);
        if (cur < tgt)      return cur + 3'd1;
        else if (cur > tgt) return cur - 3'd1;
        else                return cur;
    endfunction

endpackage

// File: rtl/chip8_tick_gen.sv
// Free-running divider: pulse is high for the single cycle the counter sits
// at DIV-1, and the counter wraps on that cycle. clr restarts the count.
module chip8_tick_gen #(
    parameter int unsigned DIV = 2
) (
    input  logic clk_m,
    input  logic rst,
    input  logic clr,
    output logic pulse
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign pulse = (cnt == LAST);

    always_ff @(posedge clk_m) begin
        if (rst || clr || pulse) cnt <= '0;
        else                     cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/chip8_sound_ctrl.sv
// CHIP-8 sound controller: sound timer, 60 Hz tick, tick-aligned config commit
// and, with CHIP8_SOUND_ENVELOPE_EN defined, an attack/release volume envelope.
module chip8_sound_ctrl
    import chip8_audio_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1666667,
    parameter int unsigned RAMP_DIV = 4096,
    parameter logic [9:0]  TONE_RST = 10'd440,
    parameter logic [2:0]  VOL_RST  = 3'd7
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       st_we_in,
    input  logic [7:0] st_data_in,
    input  logic       cfg_we_in,
    input  logic [1:0] cfg_addr_in,
    input  logic [9:0] cfg_data_in,
    input  logic       pause_in,
    output logic       tick_out,
    output logic [7:0] st_out,
    output logic       active_out,
    output logic [1:0] timbre_out,
    output logic [9:0] tone_out,
    output logic [2:0] vol_out
);

    logic       idle;
    logic [1:0] sh_timbre, nx_timbre;
    logic [9:0] sh_tone, nx_tone;
    logic [2:0] sh_vol, nx_vol, vol_tgt;
    logic       commit;

    chip8_tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk_m (clk_in),
        .rst   (rst_in),
        .clr   (1'b0),
        .pulse (tick_out)
    );

    // Sound timer: a load beats a same-cycle decrement.
    always_ff @(posedge clk_in) begin
        if (rst_in)                                   st_out <= 8'd0;
        else if (st_we_in)                            st_out <= st_data_in;
        else if (tick_out && st_out != 8'd0 && !pause_in) st_out <= st_out - 8'd1;
    end

    // Forward a same-cycle write so a commit never drops fresh data.
    always_comb begin
        nx_timbre = sh_timbre;
        nx_tone   = sh_tone;
        nx_vol    = sh_vol;
        if (cfg_we_in) begin
            case (cfg_addr_in)
                CFG_TIMBRE: nx_timbre = cfg_data_in[1:0];
                CFG_TONE:   nx_tone   = cfg_data_in;
                CFG_VOL:    nx_vol    = cfg_data_in[2:0];
                default:    ;
            endcase
        end
    end

    assign commit = tick_out || idle;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sh_timbre  <= TIMBRE_SINE;
            sh_tone    <= TONE_RST;
            sh_vol     <= VOL_RST;
            timbre_out <= TIMBRE_SINE;
            tone_out   <= TONE_RST;
            vol_tgt    <= VOL_RST;
        end else begin
            sh_timbre <= nx_timbre;
            sh_tone   <= nx_tone;
            sh_vol    <= nx_vol;
            if (commit) begin
                timbre_out <= nx_timbre;
                tone_out   <= nx_tone;
                vol_tgt    <= nx_vol;
            end
        end
    end

`ifdef CHIP8_SOUND_ENVELOPE_EN
    env_state_t state, state_nx;
    logic [2:0] vol_q, vol_nx;
    logic       step;

    chip8_tick_gen #(.DIV(RAMP_DIV)) u_ramp (
        .clk_m (clk_in),
        .rst   (rst_in),
        .clr   (state_nx != state),
        .pulse (step)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
            vol_q <= 3'd0;
        end else begin
            state <= state_nx;
            vol_q <= vol_nx;
        end
    end

    always_comb begin
        state_nx = state;
        vol_nx   = vol_q;
        case (state)
            IDLE: begin
                vol_nx = 3'd0;
                if (st_out != 8'd0) state_nx = ATTACK;
            end
            ATTACK: begin
                if (st_out == 8'd0)       state_nx = RELEASE;
                else if (vol_q >= vol_tgt) state_nx = SUSTAIN;
                else if (step)            vol_nx = (vol_q == 3'd7) ? vol_q : vol_q + 3'd1;
            end
            SUSTAIN: begin
                if (st_out == 8'd0) state_nx = RELEASE;
                else if (step)      vol_nx = vol_toward(vol_q, vol_tgt);
            end
            RELEASE: begin
                // Re-attack starts from the current level, so no click to zero.
                if (st_out != 8'd0)    state_nx = ATTACK;
                else if (vol_q == 3'd0) state_nx = IDLE;
                else if (step)         vol_nx = vol_q - 3'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign idle       = (state == IDLE);
    assign active_out = (state != IDLE);
    assign vol_out    = vol_q;
`else
    logic active_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) active_q <= 1'b0;
        else        active_q <= (st_out != 8'd0);
    end

    assign idle       = (st_out == 8'd0);
    assign active_out = active_q;
    assign vol_out    = active_q ? vol_tgt : 3'd0;
`endif

endmodule

// File: tb/tb_chip8_sound_ctrl.sv
// Directed bench for chip8_sound_ctrl with TICK_DIV=10, RAMP_DIV=2; the
// envelope scenarios are selected by CHIP8_SOUND_ENVELOPE_EN.
module tb_chip8_sound_ctrl;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       st_we_in = 1'b0;
    logic [7:0] st_data_in = 8'd0;
    logic       cfg_we_in = 1'b0;
    logic [1:0] cfg_addr_in = 2'd0;
    logic [9:0] cfg_data_in = 10'd0;
    logic       pause_in = 1'b0;
    logic       tick_out;
    logic [7:0] st_out;
    logic       active_out;
    logic [1:0] timbre_out;
    logic [9:0] tone_out;
    logic [2:0] vol_out;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk_in = ~clk_in;

    chip8_sound_ctrl #(
        .TICK_DIV (10),
        .RAMP_DIV (2),
        .TONE_RST (10'd440),
        .VOL_RST  (3'd7)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .st_we_in    (st_we_in),
        .st_data_in  (st_data_in),
        .cfg_we_in   (cfg_we_in),
        .cfg_addr_in (cfg_addr_in),
        .cfg_data_in (cfg_data_in),
        .pause_in    (pause_in),
        .tick_out    (tick_out),
        .st_out      (st_out),
        .active_out  (active_out),
        .timbre_out  (timbre_out),
        .tone_out    (tone_out),
        .vol_out     (vol_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d at cyc %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic wr_st(input logic [7:0] d);
        st_we_in = 1'b1; st_data_in = d;
        step();
        st_we_in = 1'b0;
    endtask

    task automatic wr_cfg(input logic [1:0] a, input logic [9:0] d);
        cfg_we_in = 1'b1; cfg_addr_in = a; cfg_data_in = d;
        step();
        cfg_we_in = 1'b0;
    endtask

    // After release, cyc counts edges since the tick counter was last zeroed.
    task automatic reset_dut();
        rst_in = 1'b1; st_we_in = 1'b0; cfg_we_in = 1'b0; pause_in = 1'b0;
        step(); step();
        chk("rst_st", st_out, 0);
        chk("rst_active", active_out, 0);
        chk("rst_vol", vol_out, 0);
        chk("rst_timbre", timbre_out, 0);
        chk("rst_tone", tone_out, 440);
        chk("rst_tick", tick_out, 0);
        rst_in = 1'b0;
        cyc = 0;
    endtask

    initial begin
        reset_dut();
        while (cyc < 50) begin
            step();
            chk("idle_tick", tick_out, (cyc % 10 == 9) ? 1 : 0);
        end
        chk("idle_st", st_out, 0);
        chk("idle_active", active_out, 0);
        chk("idle_vol", vol_out, 0);

`ifdef CHIP8_SOUND_ENVELOPE_EN
        reset_dut();
        wr_st(8'd3);                       // cyc 1
        chk("a_st", st_out, 3);
        chk("a_act_lag", active_out, 0);
        step();                            // cyc 2: ATTACK
        chk("a_act", active_out, 1);
        chk("a_vol0", vol_out, 0);
        run_to(4);  chk("a_vol1", vol_out, 1);
        run_to(16); chk("a_vol7", vol_out, 7);
        run_to(20);
        wr_cfg(2'd1, 10'd300);             // cyc 21, SUSTAIN
        chk("s_tone_hold", tone_out, 440);
        run_to(29);
        chk("s_tick", tick_out, 1);
        chk("s_tone_hold2", tone_out, 440);
        step();                            // cyc 30
        chk("s_tone_new", tone_out, 300);
        chk("s_st0", st_out, 0);
        chk("s_vol7", vol_out, 7);
        run_to(33); chk("r_vol6", vol_out, 6);
        run_to(45);
        chk("r_vol0", vol_out, 0);
        chk("r_act", active_out, 1);
        step();
        chk("r_act_off", active_out, 0);

        reset_dut();
        wr_st(8'd3);
        run_to(37);
        chk("b_vol4", vol_out, 4);
        wr_st(8'd2);                       // cyc 38
        chk("b_st2", st_out, 2);
        chk("b_vol4b", vol_out, 4);
        step();                            // cyc 39: back in ATTACK
        chk("b_act", active_out, 1);
        chk("b_vol4c", vol_out, 4);
        step();
        chk("b_st_dec", st_out, 1);
        run_to(41);
        chk("b_vol5", vol_out, 5);
        rst_in = 1'b1;
        step();
        chk("m_st", st_out, 0);
        chk("m_active", active_out, 0);
        chk("m_vol", vol_out, 0);
        chk("m_tone", tone_out, 440);
        chk("m_tick", tick_out, 0);
        rst_in = 1'b0;
        cyc = 0;
        wr_cfg(2'd1, 10'd55);
        chk("i_tone", tone_out, 55);
`else
        reset_dut();
        run_to(39);
        chk("n_tick39", tick_out, 1);
        wr_st(8'd1);                       // cyc 40: load beats decrement
        chk("n_st_ld", st_out, 1);
        chk("n_act_lag", active_out, 0);
        step();                            // cyc 41
        chk("n_act", active_out, 1);
        chk("n_vol", vol_out, 7);
        while (cyc < 50) begin
            step();
            chk("n_act_hold", active_out, 1);
            chk("n_vol_hold", vol_out, 7);
            chk("n_st", st_out, (cyc < 50) ? 1 : 0);
        end
        step();                            // cyc 51
        chk("n_act_off", active_out, 0);
        chk("n_vol_off", vol_out, 0);
        wr_st(8'd2);                       // cyc 52
        chk("p_st2", st_out, 2);
        run_to(59);
        chk("p_tick59", tick_out, 1);
        wr_st(8'd5);                       // cyc 60
        chk("p_st5", st_out, 5);
        pause_in = 1'b1;
        run_to(90);
        chk("p_paused", st_out, 5);
        pause_in = 1'b0;
        run_to(100);
        chk("p_dec", st_out, 4);
        wr_cfg(2'd1, 10'd300);             // cyc 101
        chk("c_tone_hold", tone_out, 440);
        run_to(109);
        chk("c_tone_hold2", tone_out, 440);
        step();
        chk("c_tone_new", tone_out, 300);
        run_to(119);
        wr_cfg(2'd2, 10'd3);               // cyc 120, written on tick
        chk("c_vol_tick", vol_out, 3);
        chk("c_act", active_out, 1);
        wr_cfg(2'd0, 10'd2);               // cyc 121
        chk("c_timbre_hold", timbre_out, 0);
        run_to(130);
        chk("c_timbre_new", timbre_out, 2);
        wr_cfg(2'd3, 10'h3ff);             // reserved address
        run_to(140);
        chk("c_st0", st_out, 0);
        chk("c_timbre_keep", timbre_out, 2);
        step();                            // cyc 141, idle
        chk("c_act_off", active_out, 0);
        wr_cfg(2'd1, 10'd123);             // cyc 142
        chk("c_tone_idle", tone_out, 123);
        wr_st(8'd9);
        step();                            // cyc 144
        chk("m_act_on", active_out, 1);
        chk("m_vol3", vol_out, 3);
        rst_in = 1'b1;
        step();
        chk("m_st", st_out, 0);
        chk("m_active", active_out, 0);
        chk("m_vol", vol_out, 0);
        chk("m_tone", tone_out, 440);
        chk("m_timbre", timbre_out, 0);
        chk("m_tick", tick_out, 0);
        rst_in = 1'b0;
        cyc = 0;
        wr_st(8'd1);
        step();
        chk("m_vol_rst_tgt", vol_out, 7);
        chk("m_act_again", active_out, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
